// File: rtl/firebird7_in_gate1_tessent_data_mux_seq_pkg.sv
// Shared types for the gate1 IJTAG data-override mux: channel state encoding and counter width.
package firebird7_in_gate1_tessent_data_mux_seq_pkg;

  typedef enum logic [1:0] {
    FUNC    = 2'b00,
    DRAIN_T = 2'b01,
    TEST    = 2'b10,
    DRAIN_F = 2'b11
  } mux_state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq_ch.sv
// One override channel: break-before-make handover FSM with settle counter and output mux.
module firebird7_in_gate1_tessent_data_mux_seq_ch
  import firebird7_in_gate1_tessent_data_mux_seq_pkg::*;
#(
  parameter int unsigned      WIDTH      = 3,
  parameter int unsigned      SETTLE     = 2,
  parameter logic [WIDTH-1:0] SAFE_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             select_i,
  input  logic [WIDTH-1:0] func_data_i,
  input  logic [WIDTH-1:0] ijtag_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             active_o,
  output logic             busy_o
);

  // Drain lasts SETTLE cycles: the load value covers the entry cycle already spent.
  localparam logic [CNT_W-1:0] CntLoad = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

  mux_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FUNC;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        FUNC: begin
          if (select_i) begin
            if (SETTLE == 0) begin
              state_q <= TEST;
            end else begin
              state_q <= DRAIN_T;
              cnt_q   <= CntLoad;
            end
          end
        end
        DRAIN_T: begin
          if (cnt_q == '0) state_q <= TEST;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        TEST: begin
          if (!select_i) begin
            if (SETTLE == 0) begin
              state_q <= FUNC;
            end else begin
              state_q <= DRAIN_F;
              cnt_q   <= CntLoad;
            end
          end
        end
        DRAIN_F: begin
          if (cnt_q == '0) state_q <= FUNC;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= FUNC;
      endcase
    end
  end

  // No data-path register: FUNC passes functional data with unchanged timing.
  always_comb begin
    data_o = SAFE_VALUE;
    case (state_q)
      FUNC:    data_o = func_data_i;
      TEST:    data_o = ijtag_data_i;
      default: data_o = SAFE_VALUE;
    endcase
  end

  assign active_o = (state_q == TEST);
  assign busy_o   = (state_q == DRAIN_T) || (state_q == DRAIN_F);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// Multi-channel IJTAG data-override mux with sequenced handover and functional-data capture.
module firebird7_in_gate1_tessent_data_mux_seq
  import firebird7_in_gate1_tessent_data_mux_seq_pkg::*;
#(
  parameter int unsigned      WIDTH      = 3,
  parameter int unsigned      NUM_CH     = 4,
  parameter int unsigned      SETTLE     = 2,
  parameter logic [WIDTH-1:0] SAFE_VALUE = '0
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic [NUM_CH-1:0]       ijtag_select,
  input  logic                    ijtag_capture_en,
  input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH*WIDTH-1:0] captured_data_out,
  output logic [NUM_CH-1:0]       ijtag_active,
  output logic [NUM_CH-1:0]       switch_busy
);

  if (SETTLE > (1 << CNT_W) - 1) begin : g_settle_range
    $error("SETTLE must fit the %0d-bit settle counter (0..15)", CNT_W);
  end

  logic [NUM_CH*WIDTH-1:0] capture_q;

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      capture_q <= '0;
    end else if (ijtag_capture_en) begin
      capture_q <= functional_data_in;
    end
  end

  assign captured_data_out = capture_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    firebird7_in_gate1_tessent_data_mux_seq_ch #(
      .WIDTH      (WIDTH),
      .SETTLE     (SETTLE),
      .SAFE_VALUE (SAFE_VALUE)
    ) u_ch (
      .clk_i        (ijtag_tck),
      .rst_ni       (ijtag_reset),
      .select_i     (ijtag_select[c]),
      .func_data_i  (functional_data_in[c*WIDTH +: WIDTH]),
      .ijtag_data_i (ijtag_data_in[c*WIDTH +: WIDTH]),
      .data_o       (data_out[c*WIDTH +: WIDTH]),
      .active_o     (ijtag_active[c]),
      .busy_o       (switch_busy[c])
    );
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_seq.sv
// Bench for the gate1 data-override mux: SETTLE=2 and SETTLE=0 instances on shared stimulus.
module tb_firebird7_in_gate1_tessent_data_mux_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sel;
  logic        cap_en;
  logic [11:0] func;
  logic [11:0] ij;

  logic [11:0] dout_a [2];
  logic [11:0] capo_a [2];
  logic [3:0]  act_a  [2];
  logic [3:0]  busy_a [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per channel, the live source (0 = functional, 1 = ijtag) and the
  // number of safe-value cycles still to show before the source flips.
  bit          cur  [2][4];
  int          pend [2][4];
  logic [11:0] cap_m;
  int          settle_of [2] = '{2, 0};

  always #5 clk = ~clk;

  firebird7_in_gate1_tessent_data_mux_seq #(
    .WIDTH(3), .NUM_CH(4), .SETTLE(2), .SAFE_VALUE(3'b000)
  ) dut (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_select       (sel),
    .ijtag_capture_en   (cap_en),
    .functional_data_in (func),
    .ijtag_data_in      (ij),
    .data_out           (dout_a[0]),
    .captured_data_out  (capo_a[0]),
    .ijtag_active       (act_a[0]),
    .switch_busy        (busy_a[0])
  );

  firebird7_in_gate1_tessent_data_mux_seq #(
    .WIDTH(3), .NUM_CH(4), .SETTLE(0), .SAFE_VALUE(3'b000)
  ) dut_s0 (
    .ijtag_tck          (clk),
    .ijtag_reset        (rst_n),
    .ijtag_select       (sel),
    .ijtag_capture_en   (cap_en),
    .functional_data_in (func),
    .ijtag_data_in      (ij),
    .data_out           (dout_a[1]),
    .captured_data_out  (capo_a[1]),
    .ijtag_active       (act_a[1]),
    .switch_busy        (busy_a[1])
  );

  function automatic logic [11:0] exp_dout(int i);
    logic [11:0] r;
    for (int c = 0; c < 4; c++) begin
      if (pend[i][c] > 0) r[c*3 +: 3] = 3'b000;
      else                r[c*3 +: 3] = cur[i][c] ? ij[c*3 +: 3] : func[c*3 +: 3];
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_act(int i);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (pend[i][c] == 0) && cur[i][c];
    return r;
  endfunction

  function automatic logic [3:0] exp_busy(int i);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (pend[i][c] > 0);
    return r;
  endfunction

  // Advance the model with the inputs about to be sampled, then clock the DUTs.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rst_n) begin
          cur[i][c]  = 1'b0;
          pend[i][c] = 0;
        end else if (pend[i][c] > 0) begin
          pend[i][c]--;
          if (pend[i][c] == 0) cur[i][c] = !cur[i][c];
        end else if (sel[c] != cur[i][c]) begin
          if (settle_of[i] == 0) cur[i][c] = sel[c];
          else                   pend[i][c] = settle_of[i];
        end
      end
    end
    if (!rst_n)      cap_m = '0;
    else if (cap_en) cap_m = func;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 4'hF; cap_en = 1'b0; func = 12'hABC; ij = 12'h123;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (dout_a[i] !== 12'hABC) begin
        n_bad++; $display("FAIL reset_dout[%0d]: got %h expected %h", i, dout_a[i], 12'hABC);
      end
      n_cmp++;
      if (act_a[i] !== 4'h0 || busy_a[i] !== 4'h0) begin
        n_bad++; $display("FAIL reset_flags[%0d]: got act=%h busy=%h expected 0/0", i, act_a[i],
                          busy_a[i]);
      end
      n_cmp++;
      if (capo_a[i] !== 12'h000) begin
        n_bad++; $display("FAIL reset_capture[%0d]: got %h expected 000", i, capo_a[i]);
      end
    end
  endtask

  task automatic test_settle();
    logic [2:0] exp0;
    rst_n = 1'b1; sel = 4'h0;
    step(); step();
    ij = 12'h005; func = 12'h6E2; sel = 4'h1;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp0 = (k < 3) ? 3'b000 : 3'b101;
      n_cmp++;
      if (dout_a[0][2:0] !== exp0 || dout_a[0][11:3] !== func[11:3]) begin
        n_bad++; $display("FAIL settle2_dout k+%0d: got %h expected %h", k, dout_a[0],
                          {func[11:3], exp0});
      end
      n_cmp++;
      if (busy_a[0][0] !== (k < 3) || act_a[0][0] !== (k == 3)) begin
        n_bad++; $display("FAIL settle2_flags k+%0d: got busy=%b act=%b", k, busy_a[0][0],
                          act_a[0][0]);
      end
      n_cmp++;
      if (dout_a[1][2:0] !== 3'b101 || busy_a[1] !== 4'h0 || act_a[1][0] !== 1'b1) begin
        n_bad++; $display("FAIL settle0 k+%0d: got dout=%h busy=%h act=%h expected 101/0/1", k,
                          dout_a[1][2:0], busy_a[1], act_a[1]);
      end
    end
    sel = 4'h0;
    step(); step(); step();
    n_cmp++;
    if (dout_a[0] !== func || act_a[0] !== 4'h0) begin
      n_bad++; $display("FAIL settle2_return: got %h act=%h expected %h act=0", dout_a[0],
                        act_a[0], func);
    end
  endtask

  task automatic test_withdrawn();
    logic exp_busy0, exp_act0;
    func = 12'h3C7; ij = 12'h0E2; sel = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      step();
      sel = 4'h0;
      exp_busy0 = (k == 1 || k == 2 || k == 4 || k == 5);
      exp_act0  = (k == 3);
      n_cmp++;
      if (busy_a[0][0] !== exp_busy0 || act_a[0][0] !== exp_act0) begin
        n_bad++; $display("FAIL withdrawn_flags k+%0d: got busy=%b act=%b expected %b/%b", k,
                          busy_a[0][0], act_a[0][0], exp_busy0, exp_act0);
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (dout_a[i] !== exp_dout(i)) begin
          n_bad++; $display("FAIL withdrawn_dout[%0d] k+%0d: got %h expected %h", i, k,
                            dout_a[i], exp_dout(i));
        end
      end
    end
    n_cmp++;
    if (dout_a[0][2:0] !== func[2:0]) begin
      n_bad++; $display("FAIL withdrawn_func: got %h expected %h", dout_a[0][2:0], func[2:0]);
    end
  endtask

  task automatic test_parallel();
    func = 12'h19D; ij = 12'($urandom()); sel = 4'hF;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (act_a[0] !== ((k == 3) ? 4'hF : 4'h0) || busy_a[0] !== ((k < 3) ? 4'hF : 4'h0)) begin
        n_bad++; $display("FAIL parallel_flags k+%0d: got act=%h busy=%h", k, act_a[0],
                          busy_a[0]);
      end
      n_cmp++;
      if (dout_a[0] !== ((k == 3) ? ij : 12'h000)) begin
        n_bad++; $display("FAIL parallel_dout k+%0d: got %h expected %h", k, dout_a[0],
                          (k == 3) ? ij : 12'h000);
      end
    end
    sel = 4'h0;
    step(); step(); step();
  endtask

  task automatic test_capture();
    func = 12'h5A3; cap_en = 1'b1;
    step();
    cap_en = 1'b0; func = 12'h0F0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (capo_a[i] !== 12'h5A3) begin
        n_bad++; $display("FAIL capture[%0d]: got %h expected 5a3", i, capo_a[i]);
      end
    end
    step(); step();
    n_cmp++;
    if (capo_a[0] !== 12'h5A3) begin
      n_bad++; $display("FAIL capture_hold: got %h expected 5a3", capo_a[0]);
    end
  endtask

  task automatic test_reset_mid_drain();
    sel = 4'h2;
    step();
    n_cmp++;
    if (busy_a[0] !== 4'h2) begin
      n_bad++; $display("FAIL middrain_enter: got busy=%h expected 2", busy_a[0]);
    end
    rst_n = 1'b0; cap_en = 1'b1; func = 12'h7E4;
    step();
    rst_n = 1'b1; cap_en = 1'b0; sel = 4'h0;
    n_cmp++;
    if (dout_a[0] !== 12'h7E4 || busy_a[0] !== 4'h0 || act_a[0] !== 4'h0) begin
      n_bad++; $display("FAIL middrain_reset: got %h busy=%h act=%h expected 7e4/0/0", dout_a[0],
                        busy_a[0], act_a[0]);
    end
    n_cmp++;
    if (capo_a[0] !== 12'h000) begin
      n_bad++; $display("FAIL middrain_capture: got %h expected 000", capo_a[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 3) == 0) sel[c] = !sel[c];
      rst_n  = ($urandom_range(0, 59) != 0);
      cap_en = ($urandom_range(0, 4) == 0);
      func   = 12'($urandom());
      ij     = 12'($urandom());
      step();
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (dout_a[i] !== exp_dout(i) || act_a[i] !== exp_act(i) || busy_a[i] !== exp_busy(i)
            || capo_a[i] !== cap_m) begin
          n_bad++;
          $display("FAIL random[%0d] cyc %0d: got d=%h a=%h b=%h c=%h expected d=%h a=%h b=%h c=%h",
                   i, n, dout_a[i], act_a[i], busy_a[i], capo_a[i], exp_dout(i), exp_act(i),
                   exp_busy(i), cap_m);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_withdrawn();
    test_parallel();
    test_capture();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
